// File: rtl/vga_vram_arbiter.sv
// ============================================================================
// Module   : vga_vram_arbiter
// Purpose  : Shares one single-port video RAM among the VGA pixel-fetch path
//            (absolute priority) and two game-logic ports (round-robin).
//            Every VRAM access is registered. Read data returns to its owner
//            3 cycles after the arbitration slot.
// Ports    : clk, rst_n            - clock, async active-low reset
//            disp_*                - display read request / data return
//            g0_*, g1_*            - game ports: req/we/addr/wdata in,
//                                    gnt pulse, rdata/rvalid out
//            mem_*                 - VRAM primitive (1-cycle read latency)
//            stat_g0/g1_wait_o     - per-port wait counters
// Options  : `ARB_STATS_EN builds the saturating wait counters; otherwise
//            the stat outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_vram_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  input  logic              g0_req_i,
  input  logic              g0_we_i,
  input  logic [ADDR_W-1:0] g0_addr_i,
  input  logic [DATA_W-1:0] g0_wdata_i,
  output logic              g0_gnt_o,
  output logic [DATA_W-1:0] g0_rdata_o,
  output logic              g0_rvalid_o,
  input  logic              g1_req_i,
  input  logic              g1_we_i,
  input  logic [ADDR_W-1:0] g1_addr_i,
  input  logic [DATA_W-1:0] g1_wdata_i,
  output logic              g1_gnt_o,
  output logic [DATA_W-1:0] g1_rdata_o,
  output logic              g1_rvalid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [STAT_W-1:0] stat_g0_wait_o,
  output logic [STAT_W-1:0] stat_g1_wait_o
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_G0   = 2'd2,
    TAG_G1   = 2'd3
  } tag_t;

  tag_t              win;
  logic              elig0, elig1;
  logic              rr_q, rr_d;          // 1: g1 is favoured on a tie
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              g0_gnt_q, g0_gnt_d;
  logic              g1_gnt_q, g1_gnt_d;
  tag_t              tag1_q, tag1_d;      // owner of the access now at the VRAM
  tag_t              tag2_q;              // owner of the data now on mem_rdata_i
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              g0_rvalid_q, g0_rvalid_d;
  logic [DATA_W-1:0] g0_rdata_q, g0_rdata_d;
  logic              g1_rvalid_q, g1_rvalid_d;
  logic [DATA_W-1:0] g1_rdata_q, g1_rdata_d;

  // Slot winner. A port whose grant is visible this cycle is masked so a
  // request still held in its grant cycle is not served twice.
  always_comb begin
    elig0 = g0_req_i & ~g0_gnt_q;
    elig1 = g1_req_i & ~g1_gnt_q;
    win   = TAG_NONE;
    rr_d  = rr_q;
    if (disp_req_i)           win = TAG_DISP;
    else if (elig0 && elig1)  win = rr_q ? TAG_G1 : TAG_G0;
    else if (elig0)           win = TAG_G0;
    else if (elig1)           win = TAG_G1;
    if (win == TAG_G0)      rr_d = 1'b1;
    else if (win == TAG_G1) rr_d = 1'b0;
  end

  // VRAM command, grant pulses and read-return routing.
  always_comb begin
    mem_en_d    = (win != TAG_NONE);
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    g0_gnt_d    = 1'b0;
    g1_gnt_d    = 1'b0;
    tag1_d      = TAG_NONE;
    case (win)
      TAG_DISP: begin
        mem_addr_d = disp_addr_i;
        tag1_d     = TAG_DISP;
      end
      TAG_G0: begin
        mem_we_d    = g0_we_i;
        mem_addr_d  = g0_addr_i;
        mem_wdata_d = g0_wdata_i;
        g0_gnt_d    = 1'b1;
        tag1_d      = g0_we_i ? TAG_NONE : TAG_G0;  // writes return nothing
      end
      TAG_G1: begin
        mem_we_d    = g1_we_i;
        mem_addr_d  = g1_addr_i;
        mem_wdata_d = g1_wdata_i;
        g1_gnt_d    = 1'b1;
        tag1_d      = g1_we_i ? TAG_NONE : TAG_G1;
      end
      default: ;
    endcase

    disp_valid_d = (tag2_q == TAG_DISP);
    g0_rvalid_d  = (tag2_q == TAG_G0);
    g1_rvalid_d  = (tag2_q == TAG_G1);
    disp_data_d  = disp_valid_d ? mem_rdata_i : disp_data_q;
    g0_rdata_d   = g0_rvalid_d  ? mem_rdata_i : g0_rdata_q;
    g1_rdata_d   = g1_rvalid_d  ? mem_rdata_i : g1_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      g0_gnt_q     <= 1'b0;
      g1_gnt_q     <= 1'b0;
      tag1_q       <= TAG_NONE;
      tag2_q       <= TAG_NONE;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      g0_rvalid_q  <= 1'b0;
      g0_rdata_q   <= '0;
      g1_rvalid_q  <= 1'b0;
      g1_rdata_q   <= '0;
    end else begin
      rr_q         <= rr_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      g0_gnt_q     <= g0_gnt_d;
      g1_gnt_q     <= g1_gnt_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag1_q;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      g0_rvalid_q  <= g0_rvalid_d;
      g0_rdata_q   <= g0_rdata_d;
      g1_rvalid_q  <= g1_rvalid_d;
      g1_rdata_q   <= g1_rdata_d;
    end
  end

  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign g0_gnt_o     = g0_gnt_q;
  assign g1_gnt_o     = g1_gnt_q;
  assign disp_valid_o = disp_valid_q;
  assign disp_data_o  = disp_data_q;
  assign g0_rvalid_o  = g0_rvalid_q;
  assign g0_rdata_o   = g0_rdata_q;
  assign g1_rvalid_o  = g1_rvalid_q;
  assign g1_rdata_o   = g1_rdata_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stat0_q, stat0_d;
  logic [STAT_W-1:0] stat1_q, stat1_d;

  // Count every requesting cycle that the port does not win; hold at max.
  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (g0_req_i && (win != TAG_G0) && (stat0_q != '1)) stat0_d = stat0_q + STAT_W'(1);
    if (g1_req_i && (win != TAG_G1) && (stat1_q != '1)) stat1_d = stat1_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign stat_g0_wait_o = stat0_q;
  assign stat_g1_wait_o = stat1_q;
`else
  assign stat_g0_wait_o = '0;
  assign stat_g1_wait_o = '0;
`endif

endmodule

`default_nettype wire
